// File: rtl/cpu_exec_core.sv
// Execution core of the 8-bit single-cycle CPU: decode, 8x8 register file and ALU.
// Outputs are combinational from INSTRUCTION and register state; only the register file is clocked.
module cpu_exec_core (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   input  logic        BUSYWAIT,
   input  logic [7:0]  READ_DATA,
   output logic        READ,
   output logic        WRITE,
   output logic [7:0]  ADDRESS,
   output logic [7:0]  WRITE_DATA,
   output logic        ZERO,
   output logic        BRANCH,
   output logic        JUMP,
   output logic [7:0]  OFFSET
);

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned IDX_W    = 3;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_LWI   = 8'h09;
   localparam logic [7:0] OP_SWD   = 8'h0A;
   localparam logic [7:0] OP_SWI   = 8'h0B;

   typedef enum logic [2:0] {
      ALU_FWD = 3'b000,
      ALU_ADD = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011
   } alu_op_e;

   logic [7:0]        opcode;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  rs1_idx;
   logic [IDX_W-1:0]  rs2_idx;
   logic [7:0]        imm;
   logic              unused_field_bits;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rs1_val;
   logic [DATA_W-1:0] rs2_val;
   logic [DATA_W-1:0] data2;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] wb_data;

   alu_op_e alu_op;
   logic    imm_sel;
   logic    neg_sel;
   logic    wr_en;
   logic    mem_to_reg;

   assign opcode            = INSTRUCTION[31:24];
   assign rd_idx            = INSTRUCTION[18:16];
   assign rs1_idx           = INSTRUCTION[10:8];
   assign rs2_idx           = INSTRUCTION[2:0];
   assign imm               = INSTRUCTION[7:0];
   assign OFFSET            = INSTRUCTION[23:16];
   assign unused_field_bits = &{1'b0, INSTRUCTION[15:11]};

   // Instruction decode; unknown opcodes fall through as NOP.
   always_comb begin
      alu_op     = ALU_FWD;
      imm_sel    = 1'b0;
      neg_sel    = 1'b0;
      wr_en      = 1'b0;
      mem_to_reg = 1'b0;
      READ       = 1'b0;
      WRITE      = 1'b0;
      BRANCH     = 1'b0;
      JUMP       = 1'b0;
      case (opcode)
         OP_LOADI: begin imm_sel = 1'b1; wr_en = 1'b1; end
         OP_MOV:   wr_en = 1'b1;
         OP_ADD:   begin alu_op = ALU_ADD; wr_en = 1'b1; end
         OP_SUB:   begin alu_op = ALU_ADD; neg_sel = 1'b1; wr_en = 1'b1; end
         OP_AND:   begin alu_op = ALU_AND; wr_en = 1'b1; end
         OP_OR:    begin alu_op = ALU_OR;  wr_en = 1'b1; end
         OP_J:     JUMP = 1'b1;
         OP_BEQ:   begin alu_op = ALU_ADD; neg_sel = 1'b1; BRANCH = 1'b1; end
         OP_LWD:   begin READ = 1'b1; wr_en = 1'b1; mem_to_reg = 1'b1; end
         OP_LWI:   begin READ = 1'b1; imm_sel = 1'b1; wr_en = 1'b1; mem_to_reg = 1'b1; end
         OP_SWD:   WRITE = 1'b1;
         OP_SWI:   begin WRITE = 1'b1; imm_sel = 1'b1; end
         default:  ;
      endcase
   end

   assign rs1_val = regs[rs1_idx];
   assign rs2_val = regs[rs2_idx];
   assign data2   = imm_sel ? imm : (neg_sel ? DATA_W'(~rs2_val + DATA_W'(1)) : rs2_val);

   // ALU; the reserved 1xx encodings produce zero.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_FWD: alu_result = data2;
         ALU_ADD: alu_result = DATA_W'(rs1_val + data2);
         ALU_AND: alu_result = rs1_val & data2;
         ALU_OR:  alu_result = rs1_val | data2;
         default: alu_result = '0;
      endcase
   end

   assign ADDRESS    = alu_result;
   assign WRITE_DATA = rs1_val;
   assign ZERO       = (alu_result == '0);
   assign wb_data    = mem_to_reg ? READ_DATA : alu_result;

   // Register file: asynchronous clear, write held off during a memory stall.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en && !BUSYWAIT) begin
         regs[rd_idx] <= wb_data;
      end
   end

endmodule

// File: tb/tb_cpu_exec_core.sv
// Directed testbench for cpu_exec_core; registers are observed through WRITE_DATA using a NOP with RS1 set.
module tb_cpu_exec_core;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] INSTRUCTION;
   logic        BUSYWAIT;
   logic [7:0]  READ_DATA;
   logic        READ, WRITE, ZERO, BRANCH, JUMP;
   logic [7:0]  ADDRESS, WRITE_DATA, OFFSET;

   int checks = 0;
   int errors = 0;

   cpu_exec_core dut (
      .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
      .READ_DATA(READ_DATA), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITE_DATA(WRITE_DATA), .ZERO(ZERO), .BRANCH(BRANCH), .JUMP(JUMP), .OFFSET(OFFSET)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply(input logic [31:0] instr);
      @(negedge CLK);
      INSTRUCTION = instr;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic peek(input logic [2:0] k, output logic [7:0] v);
      INSTRUCTION = {8'hFF, 8'h00, 5'b0, k, 8'h00};
      #1;
      v = WRITE_DATA;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      RESET = 1'b1; BUSYWAIT = 1'b0; READ_DATA = 8'h00;
      INSTRUCTION = {8'h00, 8'h01, 8'h00, 8'h42};
      #1;
      checks++; if (ADDRESS !== 8'h42) begin errors++; $display("FAIL reset_decode_loadi: ADDRESS=%h want 42", ADDRESS); end
      tick(); tick();
      peek(3'd1, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_no_write: r1=%h want 00", v); end
      INSTRUCTION = {8'h02, 8'h03, 8'h01, 8'h02};
      #1;
      checks++; if (ADDRESS !== 8'h00 || ZERO !== 1'b1) begin errors++; $display("FAIL reset_add: ADDRESS=%h ZERO=%b want 00/1", ADDRESS, ZERO); end
      @(negedge CLK);
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), v);
         checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", i, v); end
      end
   endtask

   task automatic test_alu();
      logic [7:0] v;
      apply({8'h00, 8'h01, 8'h00, 8'h05});
      checks++; if (ADDRESS !== 8'h05) begin errors++; $display("FAIL loadi_addr: ADDRESS=%h want 05", ADDRESS); end
      tick();
      apply({8'h00, 8'h02, 8'h00, 8'h03}); tick();
      apply({8'h02, 8'h03, 8'h01, 8'h02});
      checks++; if (ADDRESS !== 8'h08 || ZERO !== 1'b0) begin errors++; $display("FAIL add_comb: ADDRESS=%h ZERO=%b want 08/0", ADDRESS, ZERO); end
      tick(); peek(3'd3, v);
      checks++; if (v !== 8'h08) begin errors++; $display("FAIL add: r3=%h want 08", v); end
      apply({8'h03, 8'h04, 8'h01, 8'h02}); tick(); peek(3'd4, v);
      checks++; if (v !== 8'h02) begin errors++; $display("FAIL sub: r4=%h want 02", v); end
      apply({8'h04, 8'h05, 8'h01, 8'h02}); tick(); peek(3'd5, v);
      checks++; if (v !== 8'h01) begin errors++; $display("FAIL and: r5=%h want 01", v); end
      apply({8'h05, 8'h06, 8'h01, 8'h02}); tick(); peek(3'd6, v);
      checks++; if (v !== 8'h07) begin errors++; $display("FAIL or: r6=%h want 07", v); end
      apply({8'h01, 8'h07, 8'h00, 8'h01}); tick(); peek(3'd7, v);
      checks++; if (v !== 8'h05) begin errors++; $display("FAIL mov: r7=%h want 05", v); end
      apply({8'h00, 8'h01, 8'h00, 8'hFF}); tick();
      apply({8'h00, 8'h02, 8'h00, 8'h02}); tick();
      apply({8'h02, 8'h07, 8'h01, 8'h02}); tick(); peek(3'd7, v);
      checks++; if (v !== 8'h01) begin errors++; $display("FAIL add_wrap: r7=%h want 01", v); end
   endtask

   task automatic test_branch();
      logic [7:0] v;
      apply({8'h00, 8'h01, 8'h00, 8'h05}); tick();
      apply({8'h00, 8'h02, 8'h00, 8'h05}); tick();
      apply({8'h07, 8'h03, 8'h01, 8'h02});
      checks++; if (BRANCH !== 1'b1 || ZERO !== 1'b1 || ADDRESS !== 8'h00) begin errors++; $display("FAIL beq_eq: BRANCH=%b ZERO=%b ADDRESS=%h want 1/1/00", BRANCH, ZERO, ADDRESS); end
      checks++; if (JUMP !== 1'b0 || READ !== 1'b0 || WRITE !== 1'b0) begin errors++; $display("FAIL beq_ctrl: J=%b R=%b W=%b want 0/0/0", JUMP, READ, WRITE); end
      tick(); peek(3'd3, v);
      checks++; if (v !== 8'h08) begin errors++; $display("FAIL beq_eq_nowrite: r3=%h want 08", v); end
      apply({8'h00, 8'h02, 8'h00, 8'h06}); tick();
      apply({8'h07, 8'h03, 8'h01, 8'h02});
      checks++; if (BRANCH !== 1'b1 || ZERO !== 1'b0 || ADDRESS !== 8'hFF) begin errors++; $display("FAIL beq_ne: BRANCH=%b ZERO=%b ADDRESS=%h want 1/0/FF", BRANCH, ZERO, ADDRESS); end
      tick(); peek(3'd3, v);
      checks++; if (v !== 8'h08) begin errors++; $display("FAIL beq_ne_nowrite: r3=%h want 08", v); end
   endtask

   task automatic test_jump();
      logic [7:0] v;
      apply({8'h06, 8'hFE, 8'h00, 8'h00});
      checks++; if (JUMP !== 1'b1 || OFFSET !== 8'hFE) begin errors++; $display("FAIL jump: JUMP=%b OFFSET=%h want 1/FE", JUMP, OFFSET); end
      checks++; if (BRANCH !== 1'b0 || READ !== 1'b0 || WRITE !== 1'b0) begin errors++; $display("FAIL jump_ctrl: B=%b R=%b W=%b want 0/0/0", BRANCH, READ, WRITE); end
      tick(); peek(3'd6, v);
      checks++; if (v !== 8'h07) begin errors++; $display("FAIL jump_nowrite: r6=%h want 07", v); end
   endtask

   task automatic test_load_stall();
      logic [7:0] v;
      BUSYWAIT = 1'b1; READ_DATA = 8'h5A;
      apply({8'h09, 8'h05, 8'h05, 8'h20});
      for (int e = 0; e < 3; e++) begin
         checks++; if (READ !== 1'b1 || WRITE !== 1'b0 || ADDRESS !== 8'h20) begin errors++; $display("FAIL lwi_stall_ctrl%0d: R=%b W=%b ADDRESS=%h want 1/0/20", e, READ, WRITE, ADDRESS); end
         tick();
         checks++; if (WRITE_DATA !== 8'h01) begin errors++; $display("FAIL lwi_stall_hold%0d: r5=%h want 01", e, WRITE_DATA); end
      end
      @(negedge CLK);
      BUSYWAIT = 1'b0; READ_DATA = 8'hA5;
      #1;
      checks++; if (WRITE_DATA !== 8'h01) begin errors++; $display("FAIL lwi_pre_edge: r5=%h want 01", WRITE_DATA); end
      tick();
      checks++; if (WRITE_DATA !== 8'hA5) begin errors++; $display("FAIL lwi_load: r5=%h want A5", WRITE_DATA); end
      apply({8'h08, 8'h04, 8'h00, 8'h02});
      checks++; if (READ !== 1'b1 || ADDRESS !== 8'h06) begin errors++; $display("FAIL lwd_ctrl: READ=%b ADDRESS=%h want 1/06", READ, ADDRESS); end
      tick(); peek(3'd4, v);
      checks++; if (v !== 8'hA5) begin errors++; $display("FAIL lwd_load: r4=%h want A5", v); end
      BUSYWAIT = 1'b1;
      apply({8'h00, 8'h00, 8'h00, 8'h99}); tick(); peek(3'd0, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL busy_alu_nowrite: r0=%h want 00", v); end
      BUSYWAIT = 1'b0;
   endtask

   task automatic test_store();
      logic [7:0] v;
      apply({8'h00, 8'h02, 8'h00, 8'h10}); tick();
      apply({8'h00, 8'h01, 8'h00, 8'h77}); tick();
      apply({8'h0A, 8'h03, 8'h01, 8'h02});
      checks++; if (WRITE !== 1'b1 || READ !== 1'b0 || ADDRESS !== 8'h10 || WRITE_DATA !== 8'h77) begin errors++; $display("FAIL swd: W=%b R=%b ADDRESS=%h WDATA=%h want 1/0/10/77", WRITE, READ, ADDRESS, WRITE_DATA); end
      tick(); peek(3'd3, v);
      checks++; if (v !== 8'h08) begin errors++; $display("FAIL swd_nowrite: r3=%h want 08", v); end
      apply({8'h0B, 8'h03, 8'h01, 8'h33});
      checks++; if (WRITE !== 1'b1 || ADDRESS !== 8'h33 || WRITE_DATA !== 8'h77) begin errors++; $display("FAIL swi: W=%b ADDRESS=%h WDATA=%h want 1/33/77", WRITE, ADDRESS, WRITE_DATA); end
      apply({8'hFF, 8'h03, 8'h01, 8'h02});
      checks++; if (READ !== 1'b0 || WRITE !== 1'b0 || BRANCH !== 1'b0 || JUMP !== 1'b0) begin errors++; $display("FAIL undef_ctrl: R=%b W=%b B=%b J=%b want 0/0/0/0", READ, WRITE, BRANCH, JUMP); end
      tick(); peek(3'd3, v);
      checks++; if (v !== 8'h08) begin errors++; $display("FAIL undef_nowrite: r3=%h want 08", v); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      apply({8'h02, 8'h01, 8'h01, 8'h01});
      checks++; if (ADDRESS !== 8'hEE) begin errors++; $display("FAIL self_add_comb: ADDRESS=%h want EE", ADDRESS); end
      tick(); peek(3'd1, v);
      checks++; if (v !== 8'hEE) begin errors++; $display("FAIL self_add: r1=%h want EE", v); end
      apply({8'h00, 8'h02, 8'h00, 8'h11}); tick();
      apply({8'h02, 8'h02, 8'h02, 8'h01}); tick(); peek(3'd2, v);
      checks++; if (v !== 8'hFF) begin errors++; $display("FAIL chain_add: r2=%h want FF", v); end
   endtask

   task automatic test_reset_midcycle();
      logic [7:0] v;
      @(negedge CLK);
      #2;
      RESET = 1'b1;
      peek(3'd1, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL midreset_r1: got %h want 00", v); end
      peek(3'd2, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL midreset_r2: got %h want 00", v); end
      INSTRUCTION = {8'h00, 8'h01, 8'h00, 8'h55};
      tick(); peek(3'd1, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL midreset_nowrite: r1=%h want 00", v); end
      @(negedge CLK);
      RESET = 1'b0;
      apply({8'h00, 8'h01, 8'h00, 8'h55}); tick(); peek(3'd1, v);
      checks++; if (v !== 8'h55) begin errors++; $display("FAIL post_reset_write: r1=%h want 55", v); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_jump();
      test_load_stall();
      test_store();
      test_back_to_back();
      test_reset_midcycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
